// File: rtl/dmux8way16_buf.sv
// dmux8way16_buf: registered 1-to-8 word distributor (inverse of Mux8Way16).
// One valid/ready input stream is steered into one of eight lane holding
// registers a..h. Each lane raises its own vld bit and drops it on its own ack.
//
// Handshakes:
//   input side : a word transfers on a rising clock edge where in_vld & in_rdy.
//                in_rdy never depends on in_vld. While in_vld=1 and in_rdy=0
//                the producer holds in and sel stable.
//   lane side  : lane i is consumed on a rising edge where vld[i] & ack[i].
//                ack[i] with vld[i]=0 is ignored.
//
// Optional feature: define AUTO_SEL_EN to ignore sel and use an internal 3-bit
// round-robin pointer that advances on every accepted word (wraps 7->0).
// The per-lane EMPTY/FULL state is exposed directly on vld; ptr exposes the
// current destination lane.
module dmux8way16_buf #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [2:0]       sel,
  input  logic [7:0]       ack,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [7:0]       vld,
  output logic [2:0]       ptr
);

  logic [WIDTH-1:0] lane_q [8];
  logic [WIDTH-1:0] lane_d [8];
  logic [7:0]       vld_q;
  logic [7:0]       vld_d;
  logic [2:0]       tgt;
  logic             accept;

`ifdef AUTO_SEL_EN
  logic [2:0] ptr_q;
  logic [2:0] ptr_d;
  logic       unused_sel;

  // sel has no meaning in round-robin mode
  assign unused_sel = ^sel;
  assign tgt        = ptr_q;

  // Pointer moves only on an accepted word, so a stall keeps the same lane
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = ptr_q + 3'd1;
  end

  // Round-robin pointer register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= 3'd0;
    else       ptr_q <= ptr_d;
  end
`else
  assign tgt = sel;
`endif

  // A full lane that is being acked this cycle can be refilled in the same edge
  assign in_rdy = ~vld_q[tgt] | ack[tgt];
  assign accept = in_vld & in_rdy;

  // Next lane state: acks clear valid bits, an accepted write sets its lane again
  always_comb begin
    vld_d = vld_q & ~ack;
    for (int i = 0; i < 8; i++) lane_d[i] = lane_q[i];
    if (accept) begin
      vld_d[tgt]  = 1'b1;
      lane_d[tgt] = in;
    end
  end

  // Lane data and valid registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < 8; i++) lane_q[i] <= RESET_VAL;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < 8; i++) lane_q[i] <= lane_d[i];
    end
  end

  assign a   = lane_q[0];
  assign b   = lane_q[1];
  assign c   = lane_q[2];
  assign d   = lane_q[3];
  assign e   = lane_q[4];
  assign f   = lane_q[5];
  assign g   = lane_q[6];
  assign h   = lane_q[7];
  assign vld = vld_q;
  assign ptr = tgt;

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Bench for dmux8way16_buf. Inputs change 1 time unit after the rising edge;
// the monitor samples on the falling edge, compares against a lane-level
// reference model, then advances the model for the coming rising edge.
module tb_dmux8way16_buf;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] din     = '0;
  logic         din_vld = 1'b0;
  logic [2:0]   sel     = 3'd0;
  logic [7:0]   ack     = 8'h00;
  wire          in_rdy;
  wire  [W-1:0] a, b, c, d, e, f, g, h;
  wire  [7:0]   vld;
  wire  [2:0]   ptr;
  wire  [W-1:0] lane_w [8];

  assign lane_w[0] = a;
  assign lane_w[1] = b;
  assign lane_w[2] = c;
  assign lane_w[3] = d;
  assign lane_w[4] = e;
  assign lane_w[5] = f;
  assign lane_w[6] = g;
  assign lane_w[7] = h;

  dmux8way16_buf #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clock (clk),
    .reset (rst),
    .in    (din),
    .in_vld(din_vld),
    .in_rdy(in_rdy),
    .sel   (sel),
    .ack   (ack),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .vld   (vld),
    .ptr   (ptr)
  );

  // ---------------- reference model + scoreboard ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [7:0]   m_vld;
  logic [W-1:0] m_data [8];
  int           m_ptr;
  logic [W+2:0] exp_q[$];   // {lane, word} for every word written but not yet consumed
  bit           rejected = 1'b0;
  int           m_tgt;
  bit           m_rdy;
  bit           m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld = 8'h00;
    m_ptr = 0;
    for (int i = 0; i < 8; i++) m_data[i] = '0;
    exp_q.delete();
    rejected = 1'b0;
  endtask

  // Pop the oldest outstanding word for a lane and compare what the consumer sees
  task automatic pop_check(input int lane);
    int idx;
    idx = -1;
    for (int j = 0; j < exp_q.size(); j++)
      if (idx < 0 && int'(exp_q[j][W+2:W]) == lane) idx = j;
    if (idx < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_missing: lane %0d consumed with no expected word", lane);
    end else begin
      check($sformatf("consume_lane%0d", lane), 32'(lane_w[lane]), 32'(exp_q[idx][W-1:0]));
      exp_q.delete(idx);
    end
  endtask

  initial model_reset();

  // Monitor: compare state, then step the model for the upcoming edge
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
`ifdef AUTO_SEL_EN
      m_tgt = m_ptr;
`else
      m_tgt = int'(sel);
`endif
      check("vld", 32'(vld), 32'(m_vld));
      check("ptr", 32'(ptr), 32'(m_tgt));
      for (int i = 0; i < 8; i++)
        check($sformatf("lane%0d", i), 32'(lane_w[i]), 32'(m_data[i]));
      m_rdy = !m_vld[m_tgt] || ack[m_tgt];
      check("in_rdy", 32'(in_rdy), 32'(m_rdy));
      for (int i = 0; i < 8; i++)
        if (ack[i] && m_vld[i]) begin
          pop_check(i);
          m_vld[i] = 1'b0;
        end
      m_acc    = din_vld && m_rdy;
      rejected = din_vld && !m_rdy;
      if (m_acc) begin
        m_vld[m_tgt]  = 1'b1;
        m_data[m_tgt] = din;
        exp_q.push_back({3'(m_tgt), din});
        m_ptr = (m_ptr + 1) % 8;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit v, input logic [2:0] s, input logic [W-1:0] dd, input logic [7:0] k);
    @(posedge clk);
    #1;
    din_vld = v;
    sel     = s;
    din     = dd;
    ack     = k;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Steer word k into lane k (round-robin from 0 gives the same lanes)
    for (int k = 0; k < 8; k++) drive(1'b1, 3'(k), W'(k), 8'h00);
    drive(1'b0, 3'd0, '0, 8'h00);
    @(negedge clk);
    check("steer_vld", 32'(vld), 32'h0000_00FF);
    for (int k = 0; k < 8; k++) check($sformatf("steer_lane%0d", k), 32'(lane_w[k]), 32'(k));

`ifndef AUTO_SEL_EN
    // Back-pressure on a full lane, then refill while it is acked
    drive(1'b1, 3'd3, 16'hBEEF, 8'h00);
    @(negedge clk);
    check("bp_rdy_low", 32'(in_rdy), 32'd0);
    drive(1'b1, 3'd3, 16'hBEEF, 8'h08);
    @(negedge clk);
    check("bp_rdy_ack", 32'(in_rdy), 32'd1);
    drive(1'b0, 3'd3, '0, 8'h00);
    @(negedge clk);
    check("bp_d", 32'(d), 32'h0000_BEEF);
    check("bp_vld", 32'(vld), 32'h0000_00FF);
`endif

    // Async reset in the middle of a cycle with every lane full
    sel = 3'd5;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_rdy", 32'(in_rdy), 32'd1);
    for (int k = 0; k < 8; k++) check($sformatf("rst_lane%0d", k), 32'(lane_w[k]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

`ifndef AUTO_SEL_EN
    // Consume with extra ack on an empty lane
    drive(1'b1, 3'd0, 16'h1111, 8'h00);
    drive(1'b1, 3'd2, 16'h2222, 8'h00);
    drive(1'b0, 3'd0, '0, 8'h00);
    @(negedge clk);
    check("cons_vld_pre", 32'(vld), 32'h05);
    drive(1'b0, 3'd0, '0, 8'h07);
    drive(1'b0, 3'd0, '0, 8'h00);
    @(negedge clk);
    check("cons_vld", 32'(vld), 32'h00);
    check("cons_a", 32'(a), 32'h1111);
    check("cons_c", 32'(c), 32'h2222);
`else
    // Round-robin with every lane acked each cycle
    for (int k = 1; k <= 10; k++) drive(1'b1, 3'(k), W'(k), 8'hFF);
    drive(1'b0, 3'd0, '0, 8'h00);
    @(negedge clk);
    check("rr_a", 32'(a), 32'h9);
    check("rr_b", 32'(b), 32'hA);
    for (int k = 2; k < 8; k++) check($sformatf("rr_lane%0d", k), 32'(lane_w[k]), 32'(k + 1));
    check("rr_ptr", 32'(ptr), 32'd2);
    // Stall: fill all lanes so ptr returns to a full lane a
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) drive(1'b1, 3'd0, W'(k + 16'h100), 8'h00);
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 3'd0, 16'h0ABC, 8'h00);
      @(negedge clk);
      check("stall_ptr", 32'(ptr), 32'd0);
      check("stall_rdy", 32'(in_rdy), 32'd0);
    end
`endif

    // Randomized traffic; a rejected word is held unchanged
    for (int n = 0; n < 500; n++) begin
      if (rejected)
        drive(din_vld, sel, din, 8'($urandom_range(0, 255) & $urandom_range(0, 255)));
      else
        drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), W'($urandom),
              8'($urandom_range(0, 255) & $urandom_range(0, 255)));
    end
    // Drain every lane
    drive(1'b0, 3'd0, '0, 8'hFF);
    drive(1'b0, 3'd0, '0, 8'h00);
    @(negedge clk);
    check("drain_vld", 32'(vld), 32'd0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
